// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the shared 32-bit ALU and barrel shifter; MUL runs as a shift-add loop.
// Optional build macro: MUL_EARLY_EXIT_EN ends MUL once the remaining multiplier bits are zero.
module alu_cmd_sequencer #(
    parameter int MUL_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_overflow,
    output logic [31:0] aluSrc1,
    output logic [31:0] aluSrc2,
    output logic        invertA,
    output logic        invertB,
    output logic [1:0]  operation,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic [31:0] sftSrc,
    output logic [4:0]  shamt,
    output logic        leftRight,
    input  logic [31:0] sft_result
);
    localparam int DATA_W = 32;
    localparam int CW     = $clog2(MUL_STEPS + 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [DATA_W-1:0]   acc, mcand, mplier;
    logic [CW-1:0]       count;
    logic [DATA_W-1:0]   mul_acc_nxt;
    logic                mul_done;
    logic                is_alu_op;

    assign cmd_ready   = (state == IDLE);
    assign rsp_valid   = (state == DONE);
    assign mul_acc_nxt = mplier[0] ? alu_result : acc;
    assign is_alu_op   = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_ADD) ||
                         (op_q == OP_SUB) || (op_q == OP_SLT);

`ifdef MUL_EARLY_EXIT_EN
    assign mul_done = (count == CW'(MUL_STEPS - 1)) || (mplier[DATA_W-1:1] == '0);
`else
    assign mul_done = (count == CW'(MUL_STEPS - 1));
`endif

    always_comb begin
        state_nxt = state;
        aluSrc1   = '0;
        aluSrc2   = '0;
        invertA   = 1'b0;
        invertB   = 1'b0;
        operation = 2'b00;
        sftSrc    = '0;
        shamt     = '0;
        leftRight = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = (cmd_op == OP_MUL) ? MUL : EXEC;
            end
            EXEC: begin
                state_nxt = DONE;
                case (op_q)
                    OP_AND: begin aluSrc1 = a_q; aluSrc2 = b_q; operation = 2'b00; end
                    OP_OR:  begin aluSrc1 = a_q; aluSrc2 = b_q; operation = 2'b01; end
                    OP_ADD: begin aluSrc1 = a_q; aluSrc2 = b_q; operation = 2'b10; end
                    OP_SUB: begin aluSrc1 = a_q; aluSrc2 = b_q; operation = 2'b10; invertB = 1'b1; end
                    OP_SLT: begin aluSrc1 = a_q; aluSrc2 = b_q; operation = 2'b11; invertB = 1'b1; end
                    OP_SLL: begin sftSrc = a_q; shamt = b_q[4:0]; leftRight = 1'b1; end
                    OP_SRL: begin sftSrc = a_q; shamt = b_q[4:0]; leftRight = 1'b0; end
                    default: ;
                endcase
            end
            MUL: begin
                // acc + mcand on the ALU while the shifter doubles mcand for the next step
                aluSrc1   = acc;
                aluSrc2   = mcand;
                operation = 2'b10;
                sftSrc    = mcand;
                shamt     = 5'd1;
                leftRight = 1'b1;
                if (mul_done) state_nxt = DONE;
            end
            DONE: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            count        <= '0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        a_q    <= cmd_a;
                        b_q    <= cmd_b;
                        acc    <= '0;
                        mcand  <= cmd_a;
                        mplier <= cmd_b;
                        count  <= '0;
                    end
                end
                EXEC: begin
                    rsp_result   <= is_alu_op ? alu_result : sft_result;
                    rsp_zero     <= is_alu_op ? alu_zero : (sft_result == '0);
                    rsp_overflow <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_overflow : 1'b0;
                end
                MUL: begin
                    acc    <= mul_acc_nxt;
                    mcand  <= sft_result;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (mul_done) begin
                        rsp_result   <= mul_acc_nxt;
                        rsp_zero     <= (mul_acc_nxt == '0);
                        rsp_overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: models the external ALU/shifter and checks responses against plain arithmetic.
// Honours MUL_EARLY_EXIT_EN for expected MUL latency.
module tb_alu_cmd_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_overflow;
    logic [31:0] aluSrc1, aluSrc2;
    logic        invertA, invertB;
    logic [1:0]  operation;
    logic [31:0] alu_result;
    logic        alu_zero, alu_overflow;
    logic [31:0] sftSrc;
    logic [4:0]  shamt;
    logic        leftRight;
    logic [31:0] sft_result;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.MUL_STEPS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .aluSrc1(aluSrc1), .aluSrc2(aluSrc2), .invertA(invertA), .invertB(invertB),
        .operation(operation), .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .sftSrc(sftSrc), .shamt(shamt), .leftRight(leftRight), .sft_result(sft_result)
    );

    // External ALU and barrel shifter seen by the sequencer
    logic [31:0] ma, mb;
    logic [32:0] msum;
    logic        movf;
    always_comb begin
        ma   = invertA ? ~aluSrc1 : aluSrc1;
        mb   = invertB ? ~aluSrc2 : aluSrc2;
        msum = {1'b0, ma} + {1'b0, mb} + {32'b0, invertB};
        movf = (ma[31] == mb[31]) && (msum[31] != ma[31]);
        case (operation)
            2'b00:   alu_result = ma & mb;
            2'b01:   alu_result = ma | mb;
            2'b10:   alu_result = msum[31:0];
            default: alu_result = {31'b0, msum[31] ^ movf};
        endcase
        alu_zero     = (alu_result == 32'b0);
        alu_overflow = movf;
        sft_result   = leftRight ? (sftSrc << shamt) : (sftSrc >> shamt);
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        int          lat;
    } vec_t;

    function automatic logic [31:0] model_res(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] prod;
        prod = {32'b0, a} * {32'b0, b};
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return prod[31:0];
        endcase
    endfunction

    function automatic logic model_ovf(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        logic [31:0] s, d;
        s = a + b;
        d = a - b;
        if (op == 3'd2) return (a[31] == b[31]) && (s[31] != a[31]);
        if (op == 3'd3) return (a[31] != b[31]) && (d[31] != a[31]);
        return 1'b0;
    endfunction

    function automatic int model_lat(logic [2:0] op, logic [31:0] b);
        int n;
        if (op != 3'd7) return 1;
`ifdef MUL_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        return n;
`else
        n = b[0] ? 32 : 32;
        return n;
`endif
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic await_rsp(output int cyc);
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic release_rsp(string name);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({name, "_drop"}, {31'b0, rsp_valid}, 32'd0);
        check({name, "_rdy"}, {31'b0, cmd_ready}, 32'd1);
    endtask

    task automatic run_cmd(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                           logic [31:0] er, logic ez, logic eo, int el);
        int cyc;
        check({name, "_accept_rdy"}, {31'b0, cmd_ready}, 32'd1);
        issue(op, a, b);
        await_rsp(cyc);
        check({name, "_lat"}, 32'(cyc), 32'(el));
        check({name, "_res"}, rsp_result, er);
        check({name, "_zero"}, {31'b0, rsp_zero}, {31'b0, ez});
        check({name, "_ovf"}, {31'b0, rsp_overflow}, {31'b0, eo});
        check({name, "_busy"}, {31'b0, cmd_ready}, 32'd0);
        release_rsp(name);
    endtask

    task automatic check_idle_drive(string name);
        check({name, "_src1"}, aluSrc1, 32'd0);
        check({name, "_src2"}, aluSrc2, 32'd0);
        check({name, "_ctl"}, {26'b0, invertA, invertB, operation, leftRight, 1'b0}, 32'd0);
        check({name, "_sft"}, sftSrc, 32'd0);
        check({name, "_shamt"}, {27'b0, shamt}, 32'd0);
    endtask

    vec_t tbl[11];

    initial begin
        int cyc;
        logic [2:0]  rop;
        logic [31:0] ra, rb, rr;

        tbl[0]  = '{3'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1};
        tbl[1]  = '{3'd3, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0, 1};
        tbl[2]  = '{3'd4, 32'hFFFFFFFF, 32'h00000001, 32'd1,        1'b0, 1'b0, 1};
        tbl[3]  = '{3'd5, 32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0, 1};
        tbl[4]  = '{3'd6, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 1};
        tbl[5]  = '{3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
        tbl[6]  = '{3'd1, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1};
        tbl[7]  = '{3'd3, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1, 1};
`ifdef MUL_EARLY_EXIT_EN
        tbl[8]  = '{3'd7, 32'd3,        32'd5,        32'd15,       1'b0, 1'b0, 3};
        tbl[9]  = '{3'd7, 32'h00010000, 32'h00010000, 32'd0,        1'b1, 1'b0, 17};
        tbl[10] = '{3'd7, 32'd7,        32'd0,        32'd0,        1'b1, 1'b0, 1};
`else
        tbl[8]  = '{3'd7, 32'd3,        32'd5,        32'd15,       1'b0, 1'b0, 32};
        tbl[9]  = '{3'd7, 32'h00010000, 32'h00010000, 32'd0,        1'b1, 1'b0, 32};
        tbl[10] = '{3'd7, 32'd7,        32'd0,        32'd0,        1'b1, 1'b0, 32};
`endif

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 32'd0; cmd_b = 32'd0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_flags", {30'b0, rsp_zero, rsp_overflow}, 32'd0);
        check_idle_drive("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            run_cmd($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                    tbl[i].res, tbl[i].zero, tbl[i].ovf, tbl[i].lat);
        check_idle_drive("idle");

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
            rr  = model_res(rop, ra, rb);
            run_cmd($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, rr, (rr == 32'd0),
                    model_ovf(rop, ra, rb), model_lat(rop, rb));
        end

        // Backpressure: response held, second command waits until one cycle after rsp_ready
        issue(3'd2, 32'h11111111, 32'h22222222);
        await_rsp(cyc);
        check("bp_res", rsp_result, 32'h33333333);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 32'd9; cmd_b = 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_valid%0d", i), {31'b0, rsp_valid}, 32'd1);
            check($sformatf("bp_hold_res%0d", i), rsp_result, 32'h33333333);
            check($sformatf("bp_hold_busy%0d", i), {31'b0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
        check("bp_not_same_edge", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("bp_second_accepted", {31'b0, cmd_ready}, 32'd0);
        await_rsp(cyc);
        check("bp_second_lat", 32'(cyc), 32'd1);
        check("bp_second_res", rsp_result, 32'd5);
        release_rsp("bp_second");

        // Reset during MUL cycle 10
        issue(3'd7, 32'd3, 32'h0000FFFF);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("mid_busy", {31'b0, cmd_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", {31'b0, rsp_valid}, 32'd0);
        check("mrst_ready", {31'b0, cmd_ready}, 32'd1);
        check("mrst_result", rsp_result, 32'd0);
        check("mrst_flags", {30'b0, rsp_zero, rsp_overflow}, 32'd0);
        check_idle_drive("mrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0) begin
                check("mrst_no_rsp", {31'b0, rsp_valid}, 32'd0);
                break;
            end
        end
        check("mrst_idle_ready", {31'b0, cmd_ready}, 32'd1);
        run_cmd("post_rst_add", 3'd2, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
